// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads
// to instruction memory and presents one registered instruction per fetch to decode.
//
// state | meaning
// IDLE  | may issue a request at FetchPC (blocked while the skid holds data)
// WAIT  | request accepted, response at ReqPC is still to come
// DROP  | request accepted but flushed by a redirect; its response is discarded
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic        InstrValid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;

    logic accept;
    logic consume;
    logic out_free;
    logic rsp_live;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^RedirectPC[1:0];

    assign ImemReq    = Resetn & ~skid_valid_q & (state_q == IDLE);
    assign ImemAddr   = fetch_pc_q;
    assign Instr      = instr_q;
    assign PC         = pc_q;
    assign InstrValid = valid_q;

    assign accept   = ImemReq & ImemReady;
    assign consume  = valid_q & ~Stall;
    assign out_free = ~valid_q | consume;
    assign rsp_live = (state_q == WAIT) & ImemRvalid;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: if (ImemRvalid) state_d = IDLE;
            DROP: if (ImemRvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A full skid implies no request is in flight, so draining it never races a response.
        if (consume && skid_valid_q) begin
            instr_d      = skid_data_q;
            pc_d         = skid_pc_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
        end else if (rsp_live) begin
            if (out_free) begin
                instr_d = ImemRdata;
                pc_d    = req_pc_q;
                valid_d = 1'b1;
            end else begin
                skid_data_d  = ImemRdata;
                skid_pc_d    = req_pc_q;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (Redirect) begin
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            skid_valid_d = 1'b0;
            fetch_pc_d   = {RedirectPC[31:2], 2'b00};
            if ((state_q == IDLE && accept) || (state_q == WAIT && !ImemRvalid)) begin
                state_d = DROP;
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            skid_data_q  <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a 1-cycle-latency instruction memory model drives the
// main instance; a second instance with RESET_PC=32'hFFFF_FFFC covers address wrap.
module tb_if_fetch;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Resetn, Stall, Redirect, ImemReady, ImemRvalid;
    logic [31:0] RedirectPC, ImemRdata;
    logic        ImemReq, InstrValid;
    logic [31:0] ImemAddr, Instr, PC;

    logic        rst2_n, stall2, redirect2, ready2, rvalid2;
    logic [31:0] redirect_pc2, rdata2;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc2;

    int errors = 0;
    int checks = 0;

    logic        mem_hold = 1'b0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    if_fetch dut (
        .Clk(Clk), .Resetn(Resetn), .Stall(Stall), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
        .Instr(Instr), .PC(PC), .InstrValid(InstrValid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(Clk), .Resetn(rst2_n), .Stall(stall2), .Redirect(redirect2),
        .RedirectPC(redirect_pc2), .ImemReq(req2), .ImemAddr(addr2),
        .ImemReady(ready2), .ImemRvalid(rvalid2), .ImemRdata(rdata2),
        .Instr(instr2), .PC(pc2), .InstrValid(valid2)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : ((a << 12) | 32'h13);
    endfunction

    // Memory answers one cycle after the accepting edge unless mem_hold is set.
    initial begin
        ImemRvalid = 1'b0;
        ImemRdata  = 32'h0;
        forever begin
            @(negedge Clk);
            #2;
            ImemRvalid = 1'b0;
            if (mem_pend && !mem_hold) begin
                ImemRvalid = 1'b1;
                ImemRdata  = imem(mem_addr);
                mem_pend   = 1'b0;
            end
            if (ImemReq && ImemReady) begin
                mem_pend = 1'b1;
                mem_addr = ImemAddr;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        #1;
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h exp 0", InstrValid); end
        checks++; if (Instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", Instr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 00000000", PC); end
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %h exp 0", ImemReq); end
        checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 00000000", ImemAddr); end
        checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_param: got %h exp fffffffc", pc2); end
    endtask

    task automatic test_first_fetch();
        @(negedge Clk); Resetn = 1'b1; #1;
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL first_req: got %h exp 1", ImemReq); end
        checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h exp 00000000", ImemAddr); end
        @(negedge Clk); #1;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL first_wait_req: got %h exp 0", ImemReq); end
        checks++; if (ImemAddr !== 32'h4) begin errors++; $display("FAIL first_next_addr: got %h exp 00000004", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %h exp 0", InstrValid); end
        @(negedge Clk); #1;
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL first_valid: got %h exp 1", InstrValid); end
        checks++; if (Instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h exp 00500093", Instr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL first_pc: got %h exp 00000000", PC); end
    endtask

    task automatic test_stall_skid();
        Stall = 1'b1;
        @(negedge Clk); #1;
        checks++; if (PC !== 32'h0 || InstrValid !== 1'b1) begin errors++; $display("FAIL stall_hold1: got pc=%h v=%h exp pc=00000000 v=1", PC, InstrValid); end
        @(negedge Clk); #1;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_skid_req: got %h exp 0", ImemReq); end
        checks++; if (PC !== 32'h0 || Instr !== 32'h0050_0093) begin errors++; $display("FAIL stall_hold2: got pc=%h instr=%h exp 00000000/00500093", PC, Instr); end
        @(negedge Clk); #1;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_skid_req2: got %h exp 0", ImemReq); end
        checks++; if (PC !== 32'h0 || InstrValid !== 1'b1) begin errors++; $display("FAIL stall_hold3: got pc=%h v=%h exp pc=00000000 v=1", PC, InstrValid); end
        Stall = 1'b0;
        @(negedge Clk); #1;
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL skid_drain_pc: got %h exp 00000004", PC); end
        checks++; if (Instr !== 32'h4013) begin errors++; $display("FAIL skid_drain_instr: got %h exp 00004013", Instr); end
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL skid_drain_valid: got %h exp 1", InstrValid); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin errors++; $display("FAIL skid_resume: got req=%h addr=%h exp 1/00000008", ImemReq, ImemAddr); end
        mem_hold = 1'b1;
    endtask

    task automatic test_redirect_wait();
        @(negedge Clk); #1;
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h13) begin errors++; $display("FAIL consume_empty: got v=%h instr=%h exp 0/00000013", InstrValid, Instr); end
        checks++; if (ImemReq !== 1'b0 || ImemAddr !== 32'hC) begin errors++; $display("FAIL wait_state: got req=%h addr=%h exp 0/0000000c", ImemReq, ImemAddr); end
        Redirect = 1'b1; RedirectPC = 32'h40;
        @(negedge Clk); Redirect = 1'b0; mem_hold = 1'b0; #1;
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h13) begin errors++; $display("FAIL redir_wait_out: got v=%h instr=%h exp 0/00000013", InstrValid, Instr); end
        checks++; if (ImemReq !== 1'b0 || ImemAddr !== 32'h40) begin errors++; $display("FAIL redir_wait_drop: got req=%h addr=%h exp 0/00000040", ImemReq, ImemAddr); end
        @(negedge Clk); #1;
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL redir_wait_discard: got %h exp 0", InstrValid); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h40) begin errors++; $display("FAIL redir_wait_refetch: got req=%h addr=%h exp 1/00000040", ImemReq, ImemAddr); end
        @(negedge Clk); #1;
        checks++; if (ImemAddr !== 32'h44) begin errors++; $display("FAIL redir_wait_next: got %h exp 00000044", ImemAddr); end
        @(negedge Clk); #1;
        checks++; if (PC !== 32'h40 || Instr !== 32'h0004_0013 || InstrValid !== 1'b1) begin errors++; $display("FAIL redir_wait_target: got pc=%h instr=%h v=%h exp 00000040/00040013/1", PC, Instr, InstrValid); end
    endtask

    task automatic test_redirect_same_cycle();
        @(negedge Clk); Redirect = 1'b1; RedirectPC = 32'h103; #1;
        checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b0) begin errors++; $display("FAIL same_pre: got v=%h req=%h exp 0/0", InstrValid, ImemReq); end
        @(negedge Clk); Redirect = 1'b0; #1;
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h13) begin errors++; $display("FAIL same_discard: got v=%h instr=%h exp 0/00000013", InstrValid, Instr); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin errors++; $display("FAIL same_refetch: got req=%h addr=%h exp 1/00000100", ImemReq, ImemAddr); end
        repeat (2) @(negedge Clk);
        #1;
        checks++; if (PC !== 32'h100 || Instr !== 32'h0010_0013 || InstrValid !== 1'b1) begin errors++; $display("FAIL same_target: got pc=%h instr=%h v=%h exp 00000100/00100013/1", PC, Instr, InstrValid); end
    endtask

    task automatic test_redirect_over_stall();
        Stall = 1'b1;
        @(negedge Clk); #1;
        checks++; if (PC !== 32'h100 || InstrValid !== 1'b1) begin errors++; $display("FAIL ovr_hold: got pc=%h v=%h exp 00000100/1", PC, InstrValid); end
        @(negedge Clk); #1;
        checks++; if (ImemReq !== 1'b0 || PC !== 32'h100) begin errors++; $display("FAIL ovr_skid_full: got req=%h pc=%h exp 0/00000100", ImemReq, PC); end
        Redirect = 1'b1; RedirectPC = 32'h200;
        @(negedge Clk); Redirect = 1'b0; #1;
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h13) begin errors++; $display("FAIL ovr_flush: got v=%h instr=%h exp 0/00000013", InstrValid, Instr); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin errors++; $display("FAIL ovr_skid_empty: got req=%h addr=%h exp 1/00000200", ImemReq, ImemAddr); end
        repeat (2) @(negedge Clk);
        #1;
        checks++; if (PC !== 32'h200 || Instr !== 32'h0020_0013 || InstrValid !== 1'b1) begin errors++; $display("FAIL ovr_target: got pc=%h instr=%h v=%h exp 00000200/00200013/1", PC, Instr, InstrValid); end
    endtask

    task automatic test_async_reset();
        @(negedge Clk); #3; Resetn = 1'b0; #1;
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h13) begin errors++; $display("FAIL areset_out: got v=%h instr=%h exp 0/00000013", InstrValid, Instr); end
        checks++; if (PC !== 32'h0 || ImemAddr !== 32'h0 || ImemReq !== 1'b0) begin errors++; $display("FAIL areset_state: got pc=%h addr=%h req=%h exp 0/0/0", PC, ImemAddr, ImemReq); end
    endtask

    task automatic test_wrap();
        @(negedge Clk); rst2_n = 1'b1; #1;
        checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got req=%h addr=%h exp 1/fffffffc", req2, addr2); end
        @(negedge Clk); #1;
        checks++; if (addr2 !== 32'h0 || req2 !== 1'b0) begin errors++; $display("FAIL wrap_second_addr: got addr=%h req=%h exp 00000000/0", addr2, req2); end
        rvalid2 = 1'b1; rdata2 = 32'h00A0_0113;
        @(negedge Clk); rvalid2 = 1'b0; #1;
        checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || instr2 !== 32'h00A0_0113) begin errors++; $display("FAIL wrap_out: got v=%h pc=%h instr=%h exp 1/fffffffc/00a00113", valid2, pc2, instr2); end
        checks++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin errors++; $display("FAIL wrap_refetch: got req=%h addr=%h exp 1/00000000", req2, addr2); end
    endtask

    initial begin
        Resetn = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; ImemReady = 1'b1;
        rst2_n = 1'b0; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
        ready2 = 1'b1; rvalid2 = 1'b0; rdata2 = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_redirect_over_stall();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
